// File: rtl/bus_map_pkg.sv
// Address map, state and region types shared by the CPU-bus responder.
// decode_region() is the single place the address map is defined.
package bus_map_pkg;

    localparam int unsigned REGION_BITS = 13;
    localparam logic [15:0] RAM_BASE    = 16'h0000;
    localparam logic [15:0] ROM_BASE    = 16'h2000;
    localparam logic [15:0] STATUS_ADDR = 16'hFF00;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RD_DRIVE,
        WR_DONE
    } resp_state_t;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_ROM,
        REG_STATUS,
        REG_NONE
    } region_t;

    function automatic region_t decode_region(input logic [15:0] addr);
        if (addr[15:REGION_BITS] == RAM_BASE[15:REGION_BITS]) begin
            return REG_RAM;
        end
        if (addr[15:REGION_BITS] == ROM_BASE[15:REGION_BITS]) begin
            return REG_ROM;
        end
        if (addr == STATUS_ADDR) begin
            return REG_STATUS;
        end
        return REG_NONE;
    endfunction

endpackage

// File: rtl/bus_responder_if.sv
// CPU strobe/address/handshake signals plus the ROM side-load port.
// The tri-state data bus stays a plain inout net on the responder.
interface bus_responder_if;
    import bus_map_pkg::*;

    logic [15:0]            adress_bus;
    logic                   r;
    logic                   w;
    logic                   ready;
    logic                   bus_err;
    logic                   load_we;
    logic [REGION_BITS-1:0] load_addr;
    logic [7:0]             load_data;
    logic                   load_ack;

    modport master (
        output adress_bus, r, w, load_we, load_addr, load_data,
        input  ready, bus_err, load_ack
    );

    modport slave (
        input  adress_bus, r, w, load_we, load_addr, load_data,
        output ready, bus_err, load_ack
    );

endinterface

// File: rtl/bus_sram.sv
// Single-port synchronous RAM: registered read, one write port sharing the address.
// Contents are intentionally not reset.
module bus_sram
    import bus_map_pkg::*;
#(
    parameter int unsigned AW = REGION_BITS,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/bus_responder.sv
// Memory-side responder for the 8-bit CPU bus: RAM, boot ROM, status register,
// wait-state read timing and a ROM side-load port.
module bus_responder
    import bus_map_pkg::*;
#(
    parameter int unsigned WAIT_STATES   = 0,
    parameter logic [7:0]  UNMAPPED_DATA = 8'hFF
) (
    input  logic            clk,
    input  logic            reset,
    bus_responder_if.slave  bus,
    inout  wire [7:0]       date_bus
);

    localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES);

    resp_state_t            state;
    logic [2:0]             wait_cnt;
    logic [15:0]            addr_q;
    logic                   r_q;
    logic                   w_q;
    logic                   ready_q;
    logic                   bus_err_q;
    logic                   load_ack_q;

    logic                   cpu_start;
    logic                   rd_start;
    logic                   wr_start;
    logic                   rw_clash;
    logic                   load_accept;
    region_t                cur_region;
    region_t                held_region;
    logic [REGION_BITS-1:0] mem_addr;
    logic [REGION_BITS-1:0] rom_addr;
    logic                   ram_we;
    logic [7:0]             ram_q;
    logic [7:0]             rom_q;
    logic [7:0]             rd_data;
    logic                   drive_en;

    // Accesses start only on a strobe's first sampled-high cycle.
    assign cpu_start   = (state == IDLE) && ((bus.r && !r_q) || (bus.w && !w_q));
    assign rd_start    = cpu_start && bus.r && !bus.w;
    assign wr_start    = cpu_start && bus.w && !bus.r;
    assign rw_clash    = cpu_start && bus.r && bus.w;
    assign load_accept = (state == IDLE) && !bus.r && !bus.w && bus.load_we && !load_ack_q;

    assign cur_region  = decode_region(bus.adress_bus);
    assign held_region = decode_region(addr_q);

    // In IDLE the arrays see the live address so a zero-wait read is ready next cycle.
    assign mem_addr = (state == IDLE) ? bus.adress_bus[REGION_BITS-1:0]
                                      : addr_q[REGION_BITS-1:0];
    assign ram_we   = wr_start && (cur_region == REG_RAM);
    assign rom_addr = load_accept ? bus.load_addr : mem_addr;

    bus_sram #(.AW(REGION_BITS), .DW(8)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (mem_addr),
        .wdata (date_bus),
        .rdata (ram_q)
    );

    bus_sram #(.AW(REGION_BITS), .DW(8)) u_rom (
        .clk   (clk),
        .we    (load_accept),
        .addr  (rom_addr),
        .wdata (bus.load_data),
        .rdata (rom_q)
    );

    always_comb begin
        rd_data = UNMAPPED_DATA;
        case (held_region)
            REG_RAM:    rd_data = ram_q;
            REG_ROM:    rd_data = rom_q;
            REG_STATUS: rd_data = {7'b0, bus_err_q};
            default:    rd_data = UNMAPPED_DATA;
        endcase
    end

    assign drive_en = (state == RD_DRIVE) && !bus.w;
    assign date_bus = drive_en ? rd_data : 'z;

    assign bus.ready    = ready_q;
    assign bus.bus_err  = bus_err_q;
    assign bus.load_ack = load_ack_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            addr_q     <= '0;
            r_q        <= 1'b0;
            w_q        <= 1'b0;
            ready_q    <= 1'b0;
            bus_err_q  <= 1'b0;
            load_ack_q <= 1'b0;
        end else begin
            r_q        <= bus.r;
            w_q        <= bus.w;
            ready_q    <= 1'b0;
            load_ack_q <= load_accept;
            case (state)
                IDLE: begin
                    if (rw_clash) begin
                        bus_err_q <= 1'b1;
                    end else if (rd_start) begin
                        addr_q <= bus.adress_bus;
                        if (WAIT_INIT == 3'd0) begin
                            state   <= RD_DRIVE;
                            ready_q <= 1'b1;
                        end else begin
                            state    <= RD_WAIT;
                            wait_cnt <= WAIT_INIT;
                        end
                    end else if (wr_start) begin
                        addr_q  <= bus.adress_bus;
                        state   <= WR_DONE;
                        ready_q <= 1'b1;
                        case (cur_region)
                            REG_RAM: ;
                            REG_STATUS: begin
                                if (date_bus[0]) begin
                                    bus_err_q <= 1'b0;
                                end
                            end
                            default: bus_err_q <= 1'b1;
                        endcase
                    end
                end
                RD_WAIT: begin
                    wait_cnt <= wait_cnt - 3'd1;
                    if (wait_cnt == 3'd1) begin
                        state   <= RD_DRIVE;
                        ready_q <= 1'b1;
                    end
                end
                RD_DRIVE: state <= IDLE;
                WR_DONE:  state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_responder.sv
// Bench for bus_responder: a zero-wait and a three-wait instance share one stimulus
// stream and are compared every cycle against a transaction-level model.
module tb_bus_responder;

    localparam int MAXC = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    int          cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] adr;
    logic        r;
    logic        w;
    logic [1:0]  lwe;
    logic [12:0] laddr;
    logic [7:0]  ldata;
    logic        tb_drive;
    logic [7:0]  tb_data;

    wire  [7:0]  db0;
    wire  [7:0]  db3;

    bus_responder_if bus0 ();
    bus_responder_if bus3 ();

    assign bus0.adress_bus = adr;
    assign bus0.r          = r;
    assign bus0.w          = w;
    assign bus0.load_we    = lwe[0];
    assign bus0.load_addr  = laddr;
    assign bus0.load_data  = ldata;
    assign bus3.adress_bus = adr;
    assign bus3.r          = r;
    assign bus3.w          = w;
    assign bus3.load_we    = lwe[1];
    assign bus3.load_addr  = laddr;
    assign bus3.load_data  = ldata;

    assign db0 = tb_drive ? tb_data : 8'bz;
    assign db3 = tb_drive ? tb_data : 8'bz;
    // Opposite pulls make a released bus read as a known idle level.
    pulldown (db0);
    pullup   (db3);

    bus_responder #(.WAIT_STATES(0), .UNMAPPED_DATA(8'hFF)) u_ws0 (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus0),
        .date_bus (db0)
    );

    bus_responder #(.WAIT_STATES(3), .UNMAPPED_DATA(8'hFF)) u_ws3 (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus3),
        .date_bus (db3)
    );

    logic [7:0] ram_m [8192];
    logic [7:0] rom_m [8192];
    bit         exp_ready [2][MAXC];
    bit         exp_ack   [2][MAXC];
    bit         exp_drv   [2][MAXC];
    logic [7:0] exp_dat   [2][MAXC];
    bit         exp_err   [2][MAXC];
    bit         err_now   [2];

    int         n_checks = 0;
    int         n_fail   = 0;
    int         last_r_cyc;
    int         load_cyc;
    int         rdy_cyc [2];
    logic [7:0] rdy_dat [2];
    int         ack_cyc [2];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int ws(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    function automatic logic ack_of(input int k);
        return (k == 0) ? bus0.load_ack : bus3.load_ack;
    endfunction

    function automatic logic [7:0] model_read(input int k, input logic [15:0] a);
        if (a < 16'h2000) return ram_m[a[12:0]];
        if (a < 16'h4000) return rom_m[a[12:0]];
        if (a == 16'hFF00) return {7'b0, err_now[k]};
        return 8'hFF;
    endfunction

    task automatic set_err(input int k, input int from, input bit v);
        err_now[k] = v;
        for (int c = from; c < MAXC; c++) exp_err[k][c] = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // The read is sampled at the next edge; data is visible WAIT_STATES cycles after that.
    task automatic expect_read(input logic [15:0] a);
        for (int k = 0; k < 2; k++) begin
            int t;
            t = cyc + 1 + ws(k);
            exp_ready[k][t] = 1'b1;
            exp_drv[k][t]   = 1'b1;
            exp_dat[k][t]   = model_read(k, a);
            rdy_cyc[k]      = -1;
        end
    endtask

    task automatic cpu_read_held(input logic [15:0] a, input int hold);
        adr = a;
        r = 1'b1;
        last_r_cyc = cyc;
        expect_read(a);
        idle(hold);
        r = 1'b0;
        idle(6);
    endtask

    task automatic cpu_read(input logic [15:0] a);
        cpu_read_held(a, 1);
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        int s;
        adr = a;
        w = 1'b1;
        tb_drive = 1'b1;
        tb_data = d;
        s = cyc + 1;
        for (int k = 0; k < 2; k++) begin
            exp_ready[k][s] = 1'b1;
            if (a == 16'hFF00) begin
                if (d[0]) set_err(k, s, 1'b0);
            end else if (a >= 16'h2000) begin
                set_err(k, s, 1'b1);
            end
        end
        if (a < 16'h2000) ram_m[a[12:0]] = d;
        step();
        w = 1'b0;
        tb_drive = 1'b0;
        idle(4);
    endtask

    task automatic cpu_both(input logic [15:0] a, input logic [7:0] d);
        adr = a;
        r = 1'b1;
        w = 1'b1;
        tb_drive = 1'b1;
        tb_data = d;
        for (int k = 0; k < 2; k++) set_err(k, cyc + 1, 1'b1);
        step();
        r = 1'b0;
        w = 1'b0;
        tb_drive = 1'b0;
        idle(4);
    endtask

    task automatic wait_acks();
        for (int i = 0; i < 20 && lwe != 2'b00; i++) begin
            step();
            for (int k = 0; k < 2; k++) begin
                if (lwe[k] && ack_of(k)) begin
                    lwe[k] = 1'b0;
                    ack_cyc[k] = cyc;
                end
            end
        end
        n_checks++;
        if (lwe != 2'b00) begin
            n_fail++;
            $display("FAIL load_ack_timeout: pending %b, required 00 at cycle %0d", lwe, cyc);
            lwe = 2'b00;
        end
    endtask

    task automatic rom_load(input logic [12:0] o, input logic [7:0] d);
        laddr = o;
        ldata = d;
        lwe = 2'b11;
        load_cyc = cyc;
        for (int k = 0; k < 2; k++) begin
            exp_ack[k][cyc + 1] = 1'b1;
            ack_cyc[k] = -1;
        end
        rom_m[o] = d;
        wait_acks();
        idle(2);
    endtask

    // A load raised together with a read waits until the responder is idle
    // again: drive cycle, return edge, then the accepting edge.
    task automatic load_vs_read(input logic [12:0] o, input logic [7:0] d, input logic [15:0] a);
        adr = a;
        r = 1'b1;
        laddr = o;
        ldata = d;
        lwe = 2'b11;
        last_r_cyc = cyc;
        expect_read(a);
        for (int k = 0; k < 2; k++) begin
            exp_ack[k][cyc + 3 + ws(k)] = 1'b1;
            ack_cyc[k] = -1;
        end
        rom_m[o] = d;
        step();
        r = 1'b0;
        wait_acks();
        idle(2);
    endtask

    always @(negedge clk) begin : compare
        logic [7:0] act_db;
        logic [7:0] exp_db;
        logic       act_rdy;
        logic       act_err;
        logic       act_ack;
        string      nm;
        if (cyc < MAXC) begin
            for (int k = 0; k < 2; k++) begin
                nm      = (k == 0) ? "ws0" : "ws3";
                act_db  = (k == 0) ? db0 : db3;
                act_rdy = (k == 0) ? bus0.ready : bus3.ready;
                act_err = (k == 0) ? bus0.bus_err : bus3.bus_err;
                act_ack = (k == 0) ? bus0.load_ack : bus3.load_ack;
                if (tb_drive) exp_db = tb_data;
                else if (exp_drv[k][cyc]) exp_db = exp_dat[k][cyc];
                else exp_db = (k == 0) ? 8'h00 : 8'hFF;
                check({"date_bus_", nm}, act_db, exp_db);
                check({"ready_", nm}, 8'(act_rdy), 8'(exp_ready[k][cyc]));
                check({"bus_err_", nm}, 8'(act_err), 8'(exp_err[k][cyc]));
                check({"load_ack_", nm}, 8'(act_ack), 8'(exp_ack[k][cyc]));
                if (act_rdy) begin
                    rdy_cyc[k] = cyc;
                    rdy_dat[k] = act_db;
                end
            end
        end
    end

    initial begin
        #60000;
        $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        reset = 1'b0;
        adr = '0;
        r = 1'b0;
        w = 1'b0;
        lwe = 2'b00;
        laddr = '0;
        ldata = '0;
        tb_drive = 1'b0;
        tb_data = '0;
        idle(3);
        reset = 1'b1;
        idle(2);
        check("reset_ready", 8'(bus3.ready), 8'h00);
        check("reset_bus_err", 8'(bus3.bus_err), 8'h00);
        check("reset_date_bus", db3, 8'hFF);

        // Boot load then zero/three-wait reads of the reset vector.
        rom_load(13'h0000, 8'h3A);
        check("load_ack_lat", 8'(ack_cyc[0] - load_cyc), 8'd1);
        cpu_read(16'h2000);
        check("rom_data_ws0", rdy_dat[0], 8'h3A);
        check("rom_lat_ws0", 8'(rdy_cyc[0] - last_r_cyc), 8'd1);
        check("rom_lat_ws3", 8'(rdy_cyc[1] - last_r_cyc), 8'd4);

        cpu_write(16'h0123, 8'h55);
        cpu_read(16'h0123);
        check("ram_data_ws3", rdy_dat[1], 8'h55);
        check("ram_lat_ws3", 8'(rdy_cyc[1] - last_r_cyc), 8'd4);

        rom_load(13'h0005, 8'h99);
        cpu_write(16'h2005, 8'h77);
        check("rom_write_err", 8'(bus3.bus_err), 8'h01);
        cpu_read(16'h2005);
        check("rom_unchanged", rdy_dat[1], 8'h99);
        cpu_read(16'hFF00);
        check("status_set", rdy_dat[0], 8'h01);
        cpu_write(16'hFF00, 8'h01);
        check("status_clear_err", 8'(bus0.bus_err), 8'h00);
        cpu_read(16'hFF00);
        check("status_clear_rd", rdy_dat[1], 8'h00);

        cpu_read(16'h8000);
        check("unmapped_ws3", rdy_dat[1], 8'hFF);
        cpu_both(16'h0123, 8'hAA);
        check("rw_clash_err", 8'(bus3.bus_err), 8'h01);

        cpu_read_held(16'h0123, 6);
        check("held_read", rdy_dat[1], 8'h55);

        // Abort a three-wait read mid-wait with an asynchronous reset.
        adr = 16'h0123;
        r = 1'b1;
        s = cyc + 1;
        exp_ready[0][s] = 1'b1;
        exp_drv[0][s] = 1'b1;
        exp_dat[0][s] = model_read(0, 16'h0123);
        step();
        r = 1'b0;
        step();
        for (int k = 0; k < 2; k++) begin
            for (int c = cyc; c < MAXC; c++) begin
                exp_ready[k][c] = 1'b0;
                exp_drv[k][c] = 1'b0;
                exp_ack[k][c] = 1'b0;
            end
            set_err(k, cyc, 1'b0);
        end
        reset = 1'b0;
        #1;
        check("async_rst_ready", 8'(bus3.ready), 8'h00);
        check("async_rst_bus", db3, 8'hFF);
        check("async_rst_err", 8'(bus3.bus_err), 8'h00);
        idle(2);
        reset = 1'b1;
        idle(2);
        cpu_read(16'h0123);
        check("ram_kept_ws3", rdy_dat[1], 8'h55);
        check("ram_kept_ws0", rdy_dat[0], 8'h55);

        rom_load(13'h0001, 8'hC3);
        load_vs_read(13'h0001, 8'h5A, 16'h2001);
        check("clash_read_old", rdy_dat[0], 8'hC3);
        check("clash_ack_ws0", 8'(ack_cyc[0] - last_r_cyc), 8'd3);
        check("clash_ack_ws3", 8'(ack_cyc[1] - last_r_cyc), 8'd6);
        cpu_read(16'h2001);
        check("clash_load_new", rdy_dat[1], 8'h5A);

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
